dmem_mac_sequencer: RTL and testbench



---
 rtl/dmem_mac_sequencer.sv | 151 +++++++++++++++
 tb/tb_dmem_mac_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mac_sequencer.sv
// dmem_mac_sequencer: fetches len operand pairs from the data memory,
// accumulates their signed products, then writes the shifted and saturated
// sum back to a destination word and pulses done.
module dmem_mac_sequencer #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] abase,
    input  logic [AW-1:0] bbase,
    input  logic [AW-1:0] dest,
    input  logic [LW-1:0] len,
    input  logic [4:0]    shift,
    input  logic [DW-1:0] readdata,
    output logic [AW-1:0] address,
    output logic [DW-1:0] writedata,
    output logic          memread,
    output logic          memwrite,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCHA = 3'd1,
        FETCHB = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Saturation limits of a DW-bit signed word, held in accumulator width.
    localparam logic signed [63:0] SAT_MAX = {{(65-DW){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [63:0] SAT_MIN = {{(65-DW){1'b1}}, {(DW-1){1'b0}}};

    state_t             state_reg;
    logic [AW-1:0]      abase_reg;
    logic [AW-1:0]      bbase_reg;
    logic [AW-1:0]      dest_reg;
    logic [LW-1:0]      len_reg;
    logic [4:0]         shift_reg;
    logic [LW-1:0]      i_reg;
    logic [DW-1:0]      opa_reg;
    logic signed [63:0] acc_reg;
    logic [DW-1:0]      result_reg;

    logic signed [63:0] prod;
    logic signed [63:0] shifted;
    logic [DW-1:0]      sat_value;

    // Signed product of the latched A operand and the B word currently on readdata.
    assign prod = 64'($signed(opa_reg)) * 64'($signed(readdata));

    // Arithmetic shift then clamp into the signed DW-bit range.
    assign shifted = acc_reg >>> shift_reg;

    // Saturate the shifted accumulator; this is both the write data and the next result.
    always_comb begin
        if (shifted > SAT_MAX) begin
            sat_value = SAT_MAX[DW-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_value = SAT_MIN[DW-1:0];
        end else begin
            sat_value = shifted[DW-1:0];
        end
    end

    // Memory port mux decoded from the registered state; addresses wrap modulo 2^AW.
    always_comb begin
        address   = '0;
        writedata = '0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        case (state_reg)
            FETCHA: begin
                address = abase_reg + AW'(i_reg);
                memread = 1'b1;
            end
            FETCHB: begin
                address = bbase_reg + AW'(i_reg);
                memread = 1'b1;
            end
            WRITE: begin
                address   = dest_reg;
                writedata = sat_value;
                memwrite  = 1'b1;
            end
            default: begin
                address = '0;
            end
        endcase
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

    // Sequencer FSM with operand latching, accumulation and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            abase_reg  <= '0;
            bbase_reg  <= '0;
            dest_reg   <= '0;
            len_reg    <= '0;
            shift_reg  <= '0;
            i_reg      <= '0;
            opa_reg    <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        abase_reg <= abase;
                        bbase_reg <= bbase;
                        dest_reg  <= dest;
                        len_reg   <= len;
                        shift_reg <= shift;
                        acc_reg   <= '0;
                        i_reg     <= '0;
                        state_reg <= (len != '0) ? FETCHA : WRITE;
                    end
                end
                FETCHA: begin
                    opa_reg   <= readdata;
                    state_reg <= FETCHB;
                end
                FETCHB: begin
                    acc_reg   <= acc_reg + prod;
                    i_reg     <= i_reg + 1'b1;
                    state_reg <= (LW'(i_reg + 1'b1) == len_reg) ? WRITE : FETCHA;
                end
                WRITE: begin
                    result_reg <= sat_value;
                    state_reg  <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mac_sequencer.sv
// Directed bench for dmem_mac_sequencer with a behavioural data memory.
module tb_dmem_mac_sequencer;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] abase = '0;
    logic [AW-1:0] bbase = '0;
    logic [AW-1:0] dest = '0;
    logic [LW-1:0] len = '0;
    logic [4:0]    shift = '0;
    logic [DW-1:0] readdata;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic          memread;
    logic          memwrite;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;

    logic [DW-1:0] mem [0:1023];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int e0 = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int wr_off [4];
    int done_off [4];
    logic [AW-1:0] wr_addr [4];
    logic [AW-1:0] rd_log [$];
    bit conflict = 1'b0;

    dmem_mac_sequencer #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abase(abase),
        .bbase(bbase),
        .dest(dest),
        .len(len),
        .shift(shift),
        .readdata(readdata),
        .address(address),
        .writedata(writedata),
        .memread(memread),
        .memwrite(memwrite),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    // Combinational read port of the data memory model.
    assign readdata = memread ? mem[address] : '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and log memory traffic for this cycle.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (memread && memwrite) conflict = 1'b1;
        if (memread) rd_log.push_back(address);
        if (memwrite) begin
            mem[address] = writedata;
            if (wr_cnt < 4) begin
                wr_addr[wr_cnt] = address;
                wr_off[wr_cnt]  = cyc - e0;
            end
            wr_cnt++;
        end
        if (done) begin
            if (done_cnt < 4) done_off[done_cnt] = cyc - e0;
            done_cnt++;
        end
    endtask

    task automatic clear_log();
        wr_cnt   = 0;
        done_cnt = 0;
        rd_log.delete();
    endtask

    // Present a start request in an IDLE cycle; returns in cycle E0+1.
    task automatic launch(input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] d, input logic [LW-1:0] l,
                          input logic [4:0] s);
        abase = a;
        bbase = b;
        dest  = d;
        len   = l;
        shift = s;
        start = 1'b1;
        clear_log();
        e0 = cyc;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for done, then step into the following IDLE cycle.
    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 200) begin
            tick();
            n++;
        end
        check_eq({tag, ":done_seen"}, 64'(done_cnt), 64'(1));
        tick();
    endtask

    task automatic run_and_check(input string name, input logic [AW-1:0] a,
                                 input logic [AW-1:0] b, input logic [AW-1:0] d,
                                 input logic [LW-1:0] l, input logic [4:0] s,
                                 input logic [DW-1:0] exp);
        launch(a, b, d, l, s);
        wait_done(name);
        $display("run %s: dest=0x%0h len=%0d shift=%0d result=0x%0h", name, d, l, s, result);
        check_eq({name, ":mem"}, 64'(mem[d]), 64'(exp));
        check_eq({name, ":result"}, 64'(result), 64'(exp));
        check_eq({name, ":wr_cnt"}, 64'(wr_cnt), 64'(1));
        check_eq({name, ":wr_addr"}, 64'(wr_addr[0]), 64'(d));
        check_eq({name, ":wr_cycle"}, 64'(wr_off[0]), 64'(2 * int'(l) + 1));
        check_eq({name, ":done_cycle"}, 64'(done_off[0]), 64'(2 * int'(l) + 2));
        check_eq({name, ":idle_after"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int n;
        bit busy7;
        bit busy8;

        for (int k = 0; k < 1024; k++) mem[k] = '0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("reset_outs", 64'({busy, done, memread, memwrite, address, writedata, result}), 64'(0));
        rst_n = 1'b1;
        tick();

        // Basic dot product: 1*4 + 2*5 + 3*6 = 32
        mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3;
        mem[16] = 32'd4; mem[17] = 32'd5; mem[18] = 32'd6;
        run_and_check("basic", 10'h000, 10'h010, 10'h020, 5'd3, 5'd0, 32'd32);
        check_eq("basic:rd_first", 64'(rd_log[0]), 64'(10'h000));
        check_eq("basic:rd_second", 64'(rd_log[1]), 64'(10'h010));
        check_eq("basic:rd_count", 64'(rd_log.size()), 64'(6));

        // Signed product and saturation
        mem[10'h040] = 32'hFFFF_FFFD; mem[10'h050] = 32'd7;
        mem[10'h041] = 32'h7FFF_FFFF; mem[10'h051] = 32'd2;
        mem[10'h042] = 32'h8000_0000; mem[10'h052] = 32'd2;
        run_and_check("signed", 10'h040, 10'h050, 10'h060, 5'd1, 5'd0, 32'hFFFF_FFEB);
        run_and_check("sat_pos", 10'h041, 10'h051, 10'h061, 5'd1, 5'd0, 32'h7FFF_FFFF);
        run_and_check("sat_neg", 10'h042, 10'h052, 10'h062, 5'd1, 5'd0, 32'h8000_0000);
        // -21 >>> 2 = -6 (arithmetic, rounds toward minus infinity)
        run_and_check("neg_shift", 10'h040, 10'h050, 10'h065, 5'd1, 5'd2, 32'hFFFF_FFFA);

        // Address wrap with shift: (256*256 + 0*9) >>> 8 = 256
        mem[10'h3FF] = 32'd256; mem[0] = 32'd0;
        mem[10'h100] = 32'd256; mem[10'h101] = 32'd9;
        run_and_check("wrap", 10'h3FF, 10'h100, 10'h063, 5'd2, 5'd8, 32'd256);
        check_eq("wrap:rd0", 64'(rd_log[0]), 64'(10'h3FF));
        check_eq("wrap:rd2", 64'(rd_log[2]), 64'(10'h000));
        mem[0] = 32'd1;

        // Zero length writes 0 at E0+1, done at E0+2
        mem[10'h064] = 32'hDEAD_BEEF;
        run_and_check("zero_len", 10'h000, 10'h010, 10'h064, 5'd0, 5'd0, 32'd0);

        // Start while busy is ignored
        mem[10'h071] = 32'h1234_5678;
        launch(10'h000, 10'h010, 10'h070, 5'd3, 5'd0);
        tick();
        abase = 10'h040;
        dest  = 10'h071;
        len   = 5'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore");
        $display("run ignore: dest=0x070 result=0x%0h", result);
        check_eq("ignore:mem_dest", 64'(mem[10'h070]), 64'(32'd32));
        check_eq("ignore:mem_other", 64'(mem[10'h071]), 64'(32'h1234_5678));
        check_eq("ignore:result", 64'(result), 64'(32'd32));
        check_eq("ignore:wr_cnt", 64'(wr_cnt), 64'(1));
        n = 0;
        while (n < 8) begin
            tick();
            n++;
        end
        check_eq("ignore:no_restart", 64'(wr_cnt), 64'(1));

        // Reset during FETCHB of a len=4 run
        mem[3] = 32'd2; mem[19] = 32'd10;
        mem[10'h072] = 32'h55;
        launch(10'h000, 10'h010, 10'h072, 5'd4, 5'd0);
        tick();
        check_eq("rst:in_fetchb", 64'({memread, address}), 64'({1'b1, 10'h010}));
        rst_n = 1'b0;
        tick();
        check_eq("rst:outs_clear", 64'({busy, done, memread, memwrite, address, writedata, result}), 64'(0));
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        $display("run reset_abort: wr_cnt=%0d busy=%0d", wr_cnt, busy);
        check_eq("rst:no_write", 64'(wr_cnt), 64'(0));
        check_eq("rst:mem_kept", 64'(mem[10'h072]), 64'(32'h55));
        // 1*4 + 2*5 + 3*6 + 2*10 = 52
        run_and_check("after_rst", 10'h000, 10'h010, 10'h072, 5'd4, 5'd0, 32'd52);

        // Back-to-back with start held: 1*4+2*5=14, then 2*5+3*6=28
        abase = 10'h000; bbase = 10'h010; dest = 10'h073; len = 5'd2; shift = 5'd0;
        start = 1'b1;
        clear_log();
        e0 = cyc;
        busy7 = 1'b1;
        busy8 = 1'b0;
        n = 0;
        while (done_cnt < 2 && n < 60) begin
            tick();
            n++;
            if (cyc - e0 == 2) begin
                abase = 10'h001;
                bbase = 10'h011;
                dest  = 10'h074;
            end
            if (cyc - e0 == 7) busy7 = busy;
            if (cyc - e0 == 8) busy8 = busy;
        end
        start = 1'b0;
        tick();
        $display("run b2b: first=0x%0h second=0x%0h", mem[10'h073], mem[10'h074]);
        check_eq("b2b:done_cnt", 64'(done_cnt), 64'(2));
        check_eq("b2b:idle_gap", 64'(busy7), 64'(0));
        check_eq("b2b:restart", 64'(busy8), 64'(1));
        check_eq("b2b:wr0_cycle", 64'(wr_off[0]), 64'(5));
        check_eq("b2b:done0_cycle", 64'(done_off[0]), 64'(6));
        check_eq("b2b:wr1_cycle", 64'(wr_off[1]), 64'(12));
        check_eq("b2b:done1_cycle", 64'(done_off[1]), 64'(13));
        check_eq("b2b:wr1_addr", 64'(wr_addr[1]), 64'(10'h074));
        check_eq("b2b:mem0", 64'(mem[10'h073]), 64'(32'd14));
        check_eq("b2b:mem1", 64'(mem[10'h074]), 64'(32'd28));
        check_eq("b2b:result", 64'(result), 64'(32'd28));

        check_eq("rw_exclusive", 64'(conflict), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
